sa_mac_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational saturating MAC.
- Serves as the processing element (PE) of the weight-stationary systolic array. It holds a stationary weight, forwards activations to the neighbouring PE, and computes a saturating multiply-accumulate over two pipeline stages with valid tracking.
- Adds: global stall, optional full-precision product, local accumulate mode, sticky overflow flags.

---
 rtl/sa_mac_pipe.sv | 154 +++++++++++++++
 tb/tb_sa_mac_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_mac_pipe.sv
// sa_mac_pipe: processing element of the weight-stationary systolic array.
// It holds a stationary weight and forwards activations to the neighbouring PE.
// It computes a saturating multiply-accumulate over two pipeline stages with
// valid tracking, a global stall, a local accumulate mode and sticky overflow flags.
module sa_mac_pipe #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 32,
    parameter int SAT_MULT      = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic                            i_weight_we,
    input  logic signed [MUL_DATAWIDTH-1:0] i_weight,
    input  logic                            i_valid,
    input  logic signed [MUL_DATAWIDTH-1:0] i_act,
    input  logic signed [ADD_DATAWIDTH-1:0] i_psum,
    input  logic                            i_acc_en,
    input  logic                            i_clr_flags,
    output logic signed [MUL_DATAWIDTH-1:0] o_act,
    output logic                            o_act_valid,
    output logic signed [ADD_DATAWIDTH-1:0] o_psum,
    output logic                            o_valid,
    output logic signed [MUL_DATAWIDTH-1:0] o_weight,
    output logic                            o_ovf_mult,
    output logic                            o_ovf_add
);
    localparam int M = MUL_DATAWIDTH;
    localparam int A = ADD_DATAWIDTH;
    localparam int P = 2 * MUL_DATAWIDTH;

    if (ADD_DATAWIDTH < 2 * MUL_DATAWIDTH) begin : g_width_check
        $error("sa_mac_pipe: ADD_DATAWIDTH must be at least 2*MUL_DATAWIDTH");
    end

    // Architectural state
    logic signed [M-1:0] r_weight;
    logic signed [M-1:0] r_act;
    logic                r_act_valid;
    logic                r_v1;
    logic signed [A-1:0] r_prod1;
    logic signed [A-1:0] r_psum1;
    logic                r_acc1;
    logic                r_movf1;
    logic signed [A-1:0] r_psum;
    logic                r_valid;
    logic                r_ovf_mult;
    logic                r_ovf_add;

    // Datapath nets
    logic signed [P-1:0] w_prod_raw;
    logic signed [M-1:0] w_prod_sat;
    logic                w_mult_ovf;
    logic signed [A-1:0] w_prod_ext;
    logic signed [A-1:0] w_addend;
    logic signed [A:0]   w_sum;
    logic                w_add_ovf;
    logic signed [A-1:0] w_sum_sat;

    // Stage-1 product: full-width multiply, optional clamp to the operand range.
    always_comb begin
        w_prod_raw = P'(i_act) * P'(r_weight);
        // The product fits in M bits only when its top P-M+1 bits are all equal.
        w_mult_ovf = (SAT_MULT != 0) &&
                     !((&w_prod_raw[P-1:M-1]) || (~|w_prod_raw[P-1:M-1]));
        if (w_mult_ovf) begin
            w_prod_sat = w_prod_raw[P-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
        end else begin
            w_prod_sat = w_prod_raw[M-1:0];
        end
        w_prod_ext = (SAT_MULT != 0) ? A'(w_prod_sat) : A'(w_prod_raw);
    end

    // Stage-2 sum: one guard bit detects overflow, then clamp to the psum range.
    always_comb begin
        w_addend  = r_acc1 ? r_psum : r_psum1;
        w_sum     = (A + 1)'(r_prod1) + (A + 1)'(w_addend);
        w_add_ovf = (w_sum[A] != w_sum[A-1]);
        if (w_add_ovf) begin
            w_sum_sat = w_sum[A] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
        end else begin
            w_sum_sat = w_sum[A-1:0];
        end
    end

    // Weight load and activation forwarding; product above still sees the old weight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_weight    <= '0;
            r_act       <= '0;
            r_act_valid <= 1'b0;
        end else if (i_en) begin
            if (i_weight_we) r_weight <= i_weight;
            if (i_valid)     r_act    <= i_act;
            r_act_valid <= i_valid;
        end
    end

    // Stage 1: capture product, incoming psum and accumulate select.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1    <= 1'b0;
            r_prod1 <= '0;
            r_psum1 <= '0;
            r_acc1  <= 1'b0;
            r_movf1 <= 1'b0;
        end else if (i_en) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_prod1 <= w_prod_ext;
                r_psum1 <= i_psum;
                r_acc1  <= i_acc_en;
                r_movf1 <= w_mult_ovf;
            end
        end
    end

    // Stage 2: saturated result, which is also the local accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_psum  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= r_v1;
            if (r_v1) r_psum <= w_sum_sat;
        end
    end

    // Sticky flags, raised alongside the result; a same-cycle set overrides the clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf_mult <= 1'b0;
            r_ovf_add  <= 1'b0;
        end else begin
            if (i_clr_flags) begin
                r_ovf_mult <= 1'b0;
                r_ovf_add  <= 1'b0;
            end
            if (i_en && r_v1) begin
                if (r_movf1)   r_ovf_mult <= 1'b1;
                if (w_add_ovf) r_ovf_add  <= 1'b1;
            end
        end
    end

    assign o_act       = r_act;
    assign o_act_valid = r_act_valid;
    assign o_psum      = r_psum;
    assign o_valid     = r_valid;
    assign o_weight    = r_weight;
    assign o_ovf_mult  = r_ovf_mult;
    assign o_ovf_add   = r_ovf_add;

endmodule

// File: tb/tb_sa_mac_pipe.sv
// tb_sa_mac_pipe: three PE configurations driven in parallel from one set of
// directed vectors, checked every cycle against a transaction-level model.
module tb_sa_mac_pipe;
    localparam int NCFG = 3;
    localparam int CFG_SAT [NCFG] = '{0, 1, 1};
    localparam int CFG_AW  [NCFG] = '{32, 32, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, we, valid, acc, clr;
    logic signed [7:0]  w, act;
    logic signed [31:0] psum;

    logic signed [7:0]  o_act      [NCFG];
    logic               o_act_valid[NCFG];
    logic               o_valid    [NCFG];
    logic signed [7:0]  o_weight   [NCFG];
    logic               o_ovf_mult [NCFG];
    logic               o_ovf_add  [NCFG];
    logic signed [31:0] o_psum0, o_psum1;
    logic signed [15:0] o_psum2;

    sa_mac_pipe #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .SAT_MULT(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_weight_we(we), .i_weight(w),
        .i_valid(valid), .i_act(act), .i_psum(psum), .i_acc_en(acc), .i_clr_flags(clr),
        .o_act(o_act[0]), .o_act_valid(o_act_valid[0]), .o_psum(o_psum0),
        .o_valid(o_valid[0]), .o_weight(o_weight[0]), .o_ovf_mult(o_ovf_mult[0]),
        .o_ovf_add(o_ovf_add[0])
    );

    sa_mac_pipe #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(32), .SAT_MULT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_weight_we(we), .i_weight(w),
        .i_valid(valid), .i_act(act), .i_psum(psum), .i_acc_en(acc), .i_clr_flags(clr),
        .o_act(o_act[1]), .o_act_valid(o_act_valid[1]), .o_psum(o_psum1),
        .o_valid(o_valid[1]), .o_weight(o_weight[1]), .o_ovf_mult(o_ovf_mult[1]),
        .o_ovf_add(o_ovf_add[1])
    );

    sa_mac_pipe #(.MUL_DATAWIDTH(8), .ADD_DATAWIDTH(16), .SAT_MULT(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_weight_we(we), .i_weight(w),
        .i_valid(valid), .i_act(act), .i_psum(psum[15:0]), .i_acc_en(acc), .i_clr_flags(clr),
        .o_act(o_act[2]), .o_act_valid(o_act_valid[2]), .o_psum(o_psum2),
        .o_valid(o_valid[2]), .o_weight(o_weight[2]), .o_ovf_mult(o_ovf_mult[2]),
        .o_ovf_add(o_ovf_add[2])
    );

    int vectors = 0;
    int misses  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input int bits);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Model: each accepted op's result is worked out with plain arithmetic when it is
    // issued, then waits for its output slot (two enabled cycles after issue).
    longint m_w[NCFG], m_act[NCFG], m_psum[NCFG], m_last[NCFG], pend_res[NCFG];
    bit     m_actv[NCFG], m_valid[NCFG], m_fm[NCFG], m_fa[NCFG];
    bit     pend_v[NCFG], pend_om[NCFG], pend_oa[NCFG];

    always @(posedge clk) begin
        for (int c = 0; c < NCFG; c++) begin
            longint raw, p, ps, s, r;
            if (rst) begin
                m_w[c] = 0; m_act[c] = 0; m_psum[c] = 0; m_last[c] = 0; pend_res[c] = 0;
                m_actv[c] = 0; m_valid[c] = 0; m_fm[c] = 0; m_fa[c] = 0;
                pend_v[c] = 0; pend_om[c] = 0; pend_oa[c] = 0;
            end else begin
                if (clr) begin
                    m_fm[c] = 0;
                    m_fa[c] = 0;
                end
                if (en) begin
                    m_valid[c] = pend_v[c];
                    if (pend_v[c]) begin
                        m_psum[c] = pend_res[c];
                        if (pend_om[c]) m_fm[c] = 1;
                        if (pend_oa[c]) m_fa[c] = 1;
                    end
                    pend_v[c] = valid;
                    if (valid) begin
                        raw = longint'(act) * m_w[c];
                        p   = (CFG_SAT[c] != 0) ? clamp(raw, 8) : raw;
                        ps  = (CFG_AW[c] == 16) ? longint'($signed(psum[15:0])) : longint'(psum);
                        s   = p + (acc ? m_last[c] : ps);
                        r   = clamp(s, CFG_AW[c]);
                        pend_res[c] = r;
                        pend_om[c]  = (p != raw);
                        pend_oa[c]  = (r != s);
                        m_last[c]   = r;
                    end
                    m_actv[c] = valid;
                    if (valid) m_act[c] = longint'(act);
                    if (we) m_w[c] = longint'(w);
                end
            end
        end
    end

    // Compare every output of every instance against the model once per cycle.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            for (int c = 0; c < NCFG; c++) begin
                logic signed [63:0] dp;
                if (c == 0)      dp = o_psum0;
                else if (c == 1) dp = o_psum1;
                else             dp = o_psum2;
                chk($sformatf("dut%0d o_psum", c), dp, m_psum[c]);
                chk($sformatf("dut%0d o_valid", c), o_valid[c], m_valid[c]);
                chk($sformatf("dut%0d o_act", c), o_act[c], m_act[c]);
                chk($sformatf("dut%0d o_act_valid", c), o_act_valid[c], m_actv[c]);
                chk($sformatf("dut%0d o_weight", c), o_weight[c], m_w[c]);
                chk($sformatf("dut%0d o_ovf_mult", c), o_ovf_mult[c], m_fm[c]);
                chk($sformatf("dut%0d o_ovf_add", c), o_ovf_add[c], m_fa[c]);
            end
        end
    end

    task automatic drive(input bit r, input bit e, input bit wwe, input int wv, input bit v,
                         input int a, input int ps, input bit ac, input bit cl);
        @(negedge clk);
        rst = r; en = e; we = wwe; w = 8'(wv); valid = v;
        act = 8'(a); psum = 32'(ps); acc = ac; clr = cl;
    endtask

    task automatic idle(input bit cl);
        drive(0, 1, 0, 0, 0, 0, 0, 0, cl);
    endtask

    task automatic load_w(input int wv);
        drive(0, 1, 1, wv, 0, 0, 0, 0, 0);
    endtask

    task automatic op(input int a, input int ps, input bit ac);
        drive(0, 1, 0, 0, 1, a, ps, ac, 0);
    endtask

    // Literal checks run at the negedge just after driving, so they see the
    // outputs registered on the preceding rising edge.
    initial begin
        rst = 1; en = 1; we = 0; w = 0; valid = 0; act = 0; psum = 0; acc = 0; clr = 0;
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        idle(0);
        chk("reset o_psum", o_psum1, 0);
        chk("reset o_weight", o_weight[1], 0);

        // Basic MAC, full-precision product: 3*5+10.
        load_w(3);
        op(5, 10, 0);
        idle(0);
        chk("fwd o_act", o_act[0], 5);
        chk("fwd o_act_valid", o_act_valid[0], 1);
        idle(0);
        chk("basic o_psum", o_psum0, 25);
        chk("basic o_valid", o_valid[0], 1);
        chk("model basic", m_psum[0], 25);

        // Product saturation: -128*-128.
        load_w(-128);
        op(-128, 0, 0);
        idle(0);
        idle(0);
        chk("msat o_psum", o_psum1, 127);
        chk("msat o_ovf_mult", o_ovf_mult[1], 1);
        chk("nosat o_psum", o_psum0, 16384);
        chk("nosat o_ovf_mult", o_ovf_mult[0], 0);
        chk("model msat", m_psum[1], 127);
        op(0, 0, 0);
        idle(0);
        idle(0);
        chk("sticky o_ovf_mult", o_ovf_mult[1], 1);
        chk("clean o_psum", o_psum1, 0);
        idle(1);
        idle(0);
        chk("cleared o_ovf_mult", o_ovf_mult[1], 0);
        op(-128, 0, 0);
        idle(1);
        idle(0);
        chk("set-wins o_ovf_mult", o_ovf_mult[1], 1);

        // Sum saturation at 16 bits.
        idle(1);
        load_w(1);
        op(1, 32767, 0);
        op(-1, -32768, 0);
        idle(0);
        chk("asat hi o_psum", o_psum2, 32767);
        chk("asat o_ovf_add", o_ovf_add[2], 1);
        chk("wide no-sat o_psum", o_psum0, 32768);
        idle(0);
        chk("asat lo o_psum", o_psum2, -32768);

        // Back-to-back local accumulation.
        load_w(2);
        op(1, 0, 0);
        op(2, 0, 1);
        op(3, 0, 1);
        chk("acc #1", o_psum0, 2);
        op(4, 0, 1);
        chk("acc #2", o_psum0, 6);
        idle(0);
        chk("acc #3", o_psum0, 12);
        idle(0);
        chk("acc #4", o_psum0, 20);
        chk("model acc", m_psum[0], 20);

        // Weight write alongside an op: that op uses the old weight.
        load_w(2);
        drive(0, 1, 1, 5, 1, 1, 0, 0, 0);
        op(2, 0, 1);
        idle(0);
        chk("old weight o_psum", o_psum0, 2);
        idle(0);
        chk("new weight o_psum", o_psum0, 12);
        chk("new o_weight", o_weight[0], 5);

        // Stall for three cycles mid-stream; flags cleared while stalled.
        op(1, 100, 0);
        op(2, 200, 0);
        drive(0, 0, 0, 0, 1, 3, 300, 0, 0);
        drive(0, 0, 0, 0, 1, 3, 300, 0, 1);
        chk("stall o_psum", o_psum0, 105);
        chk("stall o_valid", o_valid[0], 1);
        drive(0, 0, 0, 0, 1, 3, 300, 0, 0);
        chk("stall clr o_ovf_add", o_ovf_add[2], 0);
        op(3, 300, 0);
        chk("stall end o_psum", o_psum0, 105);
        chk("stall o_act", o_act[0], 2);
        idle(0);
        chk("resume #2", o_psum0, 210);
        idle(0);
        chk("resume #3", o_psum0, 315);

        // Reset with stage 1 loaded flushes the op.
        op(7, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk("flush o_psum", o_psum0, 0);
        chk("flush o_weight", o_weight[0], 0);
        chk("flush o_act", o_act[0], 0);
        idle(0);
        chk("flush o_valid", o_valid[0], 0);
        load_w(4);
        op(2, 1, 0);
        idle(0);
        idle(0);
        chk("after reset o_psum", o_psum0, 9);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
